axi_pack_conv_r_affine: RTL and testbench



---
 rtl/axi_pack_conv_r_affine.sv | 193 +++++++++++++++++++
 tb/tb_axi_pack_conv_r_affine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pack_conv_r_affine.sv
// Affine read-data converter: splits wide AXI R beats back into the narrow
// per-element R beats of the original strided SSR request.

package axi_pack_conv_r_affine_pkg;

    localparam int unsigned IdWidth = 4;

    typedef logic [7:0] len_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [2:0]         ssr_size;
        logic [15:0]        ssr_stride;
        logic [31:0]        ssr_offset;
        logic               same_size;
        logic [5:0]         std_offset;
        len_t               ssr_len;
        logic               ssr_last;
    } sarq_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [511:0]       data;
        logic [1:0]         resp;
        logic               last;
    } axi_r_wide_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [63:0]        data;
        logic [1:0]         resp;
        logic               last;
    } axi_r_narrow_t;

endpackage

module axi_pack_conv_r_affine #(
    parameter int unsigned DataWidth_I = 64,
    parameter int unsigned DataWidth_O = 512,
    parameter type sarq_t         = axi_pack_conv_r_affine_pkg::sarq_t,
    parameter type axi_r_wide_t   = axi_pack_conv_r_affine_pkg::axi_r_wide_t,
    parameter type axi_r_narrow_t = axi_pack_conv_r_affine_pkg::axi_r_narrow_t
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  sarq_t         xsarq_out,
    input  logic          xsarq_empty,
    output logic          xsarq_pop,
    input  logic          r_valid_i,
    output logic          r_ready_o,
    input  axi_r_wide_t   r_chan_i,
    output logic          r_valid_o,
    input  logic          r_ready_i,
    output axi_r_narrow_t r_chan_o,
    output logic          protocol_err_o
);

    localparam int unsigned NbI         = DataWidth_I / 8;
    localparam int unsigned NbO         = DataWidth_O / 8;
    localparam int unsigned DataAlign_O = $clog2(NbO);
    localparam int unsigned PtrW        = DataAlign_O + 1;
    localparam int unsigned StepW       = 24;

    typedef enum logic {
        IDLE,
        EMIT
    } state_e;

    state_e state;
    sarq_t  desc;

    logic                              buf_valid_q, buf_valid_d;
    axi_r_wide_t                       buf_q;
    axi_pack_conv_r_affine_pkg::len_t  elem_cnt_q, elem_cnt_d;
    logic [PtrW-1:0]                   ptr_q, ptr_d;
    logic                              fresh_q, fresh_d;
    logic                              err_q, err_d;

    logic [PtrW-1:0]        ptr_cur, ptr_sum;
    logic [StepW-1:0]       step;
    logic                   hs_out, hs_in, is_final, complete, beat_adv, release_beat;
    logic [DataAlign_O-1:0] byte_idx;
    logic [DataWidth_I-1:0] elem_bytes, lane_data;
    logic [31:0]            lane_off;

    assign desc = xsarq_out;

    assign state     = (buf_valid_q && !xsarq_empty) ? EMIT : IDLE;
    assign r_valid_o = (state == EMIT);

    // A descriptor that has not emitted yet starts from its own std_offset.
    assign ptr_cur = fresh_q ? PtrW'(desc.std_offset) : ptr_q;

    always_comb begin
        if (desc.same_size) begin
            step = StepW'(1) << desc.ssr_size;
        end else begin
            step = (StepW'(desc.ssr_stride) + StepW'(1)) << desc.ssr_size;
        end
    end

    assign ptr_sum      = ptr_cur + step[PtrW-1:0];
    assign hs_out       = r_valid_o & r_ready_i;
    assign is_final     = (elem_cnt_q == desc.ssr_len);
    assign complete     = hs_out & is_final;
    assign beat_adv     = desc.same_size | ptr_sum[DataAlign_O] | is_final;
    assign release_beat = hs_out & beat_adv;

    assign r_ready_o = ~buf_valid_q | release_beat;
    assign hs_in     = r_valid_i & r_ready_o;
    assign xsarq_pop = complete;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        byte_idx   = '0;
        elem_bytes = '0;
        for (int b = 0; b < int'(NbI); b++) begin
            byte_idx = ptr_cur[DataAlign_O-1:0] + DataAlign_O'(b);
            if (32'(b) < (32'd1 << desc.ssr_size)) begin
                elem_bytes[b*8 +: 8] = buf_q.data[{byte_idx, 3'b000} +: 8];
            end
        end
    end

    assign lane_off  = (desc.ssr_offset + (32'(elem_cnt_q) << desc.ssr_size)) & 32'(NbI - 1);
    assign lane_data = elem_bytes << {lane_off, 3'b000};

    always_comb begin
        r_chan_o      = '0;
        r_chan_o.id   = desc.id;
        r_chan_o.data = lane_data;
        r_chan_o.resp = buf_q.resp;
        r_chan_o.last = desc.ssr_last & is_final;
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        if (hs_in) begin
            buf_valid_d = 1'b1;
        end else if (release_beat) begin
            buf_valid_d = 1'b0;
        end

        elem_cnt_d = elem_cnt_q;
        ptr_d      = ptr_q;
        fresh_d    = fresh_q;
        if (complete) begin
            elem_cnt_d = '0;
            ptr_d      = '0;
            fresh_d    = 1'b1;
        end else if (hs_out) begin
            elem_cnt_d = elem_cnt_q + 8'd1;
            ptr_d      = {1'b0, ptr_sum[DataAlign_O-1:0]};
            fresh_d    = 1'b0;
        end
    end

    // Sticky: bad last flags, id mismatch and oversized strides only flag, data keeps flowing.
    always_comb begin
        err_d = err_q;
        if (release_beat && buf_q.last && !is_final) err_d = 1'b1;
        if (complete && !buf_q.last)                 err_d = 1'b1;
        if (r_valid_o && (buf_q.id != desc.id))      err_d = 1'b1;
        if (r_valid_o && !desc.same_size && (step > StepW'(NbO))) err_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid_q <= 1'b0;
            elem_cnt_q  <= '0;
            ptr_q       <= '0;
            fresh_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            elem_cnt_q  <= elem_cnt_d;
            ptr_q       <= ptr_d;
            fresh_q     <= fresh_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the beat payload is qualified by buf_valid_q, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (hs_in) begin
            buf_q <= r_chan_i;
        end
    end

    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_axi_pack_conv_r_affine.sv
// Scoreboard bench for axi_pack_conv_r_affine: directed bursts push expected
// narrow beats, a negedge monitor pops and compares them.

module tb_axi_pack_conv_r_affine;
    import axi_pack_conv_r_affine_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i;
    sarq_t         xsarq_out;
    logic          xsarq_empty;
    logic          xsarq_pop;
    logic          r_valid_i;
    logic          r_ready_o;
    axi_r_wide_t   r_chan_i;
    logic          r_valid_o;
    logic          r_ready_i;
    axi_r_narrow_t r_chan_o;
    logic          protocol_err_o;

    axi_pack_conv_r_affine dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .xsarq_out      (xsarq_out),
        .xsarq_empty    (xsarq_empty),
        .xsarq_pop      (xsarq_pop),
        .r_valid_i      (r_valid_i),
        .r_ready_o      (r_ready_o),
        .r_chan_i       (r_chan_i),
        .r_valid_o      (r_valid_o),
        .r_ready_i      (r_ready_i),
        .r_chan_o       (r_chan_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    int            checks = 0;
    int            errors = 0;
    sarq_t         sarq_fifo[$];
    axi_r_wide_t   wide_fifo[$];
    axi_r_narrow_t exp_q[$];
    axi_r_narrow_t exp_item;
    axi_r_narrow_t held;
    logic          wide_hs_now  = 1'b0;
    logic          pop_now      = 1'b0;
    logic          stalled_prev = 1'b0;
    int            wide_hs_cnt  = 0;
    int            pop_cnt      = 0;
    int            hs_total     = 0;
    int            stall_cyc    = 0;
    int            cyc          = 0;
    int            hs_cyc[$];
    int            stall_at     = -1;
    int            stall_left   = 0;
    logic [7:0]    beat_tag     = 8'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] beat_byte(input logic [7:0] tag, input int k);
        return 8'(int'(tag) * 37 + k * 3 + 1);
    endfunction

    function automatic axi_r_wide_t mk_beat(input logic [3:0] id, input logic [7:0] tag, input logic last);
        axi_r_wide_t b;
        b = '0;
        for (int k = 0; k < 64; k++) b.data[k*8 +: 8] = beat_byte(tag, k);
        b.id   = id;
        b.resp = tag[1:0];
        b.last = last;
        return b;
    endfunction

    function automatic logic [63:0] exp_data(input logic [7:0] tag, input int ptr, input int nbytes, input int lane);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < nbytes; k++) begin
            if (ptr + k < 64 && lane + k < 8) r[(lane + k)*8 +: 8] = beat_byte(tag, ptr + k);
        end
        return r;
    endfunction

    task automatic drive();
        r_valid_i   = (wide_fifo.size() != 0);
        r_chan_i    = (wide_fifo.size() != 0) ? wide_fifo[0] : '0;
        xsarq_empty = (sarq_fifo.size() == 0);
        xsarq_out   = (sarq_fifo.size() != 0) ? sarq_fifo[0] : '0;
    endtask

    // Element e lives at byte address std_offset + e*step of the burst's beat stream.
    task automatic add_burst(input sarq_t d, input int nbeats, input int early_last);
        logic [7:0]    first_tag;
        axi_r_narrow_t e_exp;
        int            nbytes, stp, addr, bidx, ptr, lane;
        first_tag = beat_tag;
        sarq_fifo.push_back(d);
        for (int b = 0; b < nbeats; b++) begin
            wide_fifo.push_back(mk_beat(d.id, beat_tag, (b == nbeats - 1) || (b == early_last)));
            beat_tag = beat_tag + 8'd1;
        end
        nbytes = 1 << d.ssr_size;
        for (int e = 0; e <= int'(d.ssr_len); e++) begin
            if (d.same_size) begin
                bidx = e;
                ptr  = (int'(d.std_offset) + e * nbytes) % 64;
            end else begin
                stp  = (int'(d.ssr_stride) + 1) * nbytes;
                addr = int'(d.std_offset) + e * stp;
                bidx = addr / 64;
                ptr  = addr % 64;
            end
            lane        = (int'(d.ssr_offset) + e * nbytes) % 8;
            e_exp.id    = d.id;
            e_exp.data  = exp_data(first_tag + 8'(bidx), ptr, nbytes, lane);
            e_exp.resp  = 2'(first_tag + 8'(bidx));
            e_exp.last  = d.ssr_last && (e == int'(d.ssr_len));
            exp_q.push_back(e_exp);
        end
        drive();
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (wide_hs_now) begin
            void'(wide_fifo.pop_front());
            wide_hs_cnt++;
        end
        if (pop_now) begin
            void'(sarq_fifo.pop_front());
            pop_cnt++;
        end
        if (stall_left > 0) begin
            stall_left--;
            r_ready_i = 1'b0;
        end else if (hs_total == stall_at) begin
            stall_at   = -1;
            stall_left = 4;
            r_ready_i  = 1'b0;
        end else begin
            r_ready_i = 1'b1;
        end
        drive();
    endtask

    task automatic run_to_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && wide_fifo.size() == 0 && sarq_fifo.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_finished_in_budget"}, 128'(n < budget), 128'd1);
    endtask

    task automatic run_to_hs(input int target, input int budget);
        int n;
        n = 0;
        while (hs_total < target && n < budget) begin
            tick();
            n++;
        end
        check("reach_handshake_target", 128'(hs_total), 128'(target));
    endtask

    function automatic sarq_t mk_desc(input logic [3:0] id, input logic [2:0] size, input logic [15:0] stride,
                                      input logic [31:0] ofs, input logic same, input logic [5:0] std,
                                      input logic [7:0] len, input logic last);
        sarq_t d;
        d.id = id; d.ssr_size = size; d.ssr_stride = stride; d.ssr_offset = ofs;
        d.same_size = same; d.std_offset = std; d.ssr_len = len; d.ssr_last = last;
        return d;
    endfunction

    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            wide_hs_now  = 1'b0;
            pop_now      = 1'b0;
            stalled_prev = 1'b0;
        end else begin
            wide_hs_now = r_valid_i & r_ready_o;
            pop_now     = xsarq_pop;
            if (xsarq_pop) check("pop_on_handshake", 128'(r_valid_o & r_ready_i), 128'd1);
            if (r_valid_o && r_ready_i) begin
                hs_total++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_narrow_beat: got %0h expected none", r_chan_o);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("narrow_beat", 128'(r_chan_o), 128'(exp_item));
                end
            end
            if (r_valid_o && !r_ready_i) begin
                stall_cyc++;
                check("wide_ready_low_in_stall", 128'(r_ready_o), 128'd0);
                if (stalled_prev) check("narrow_chan_stable", 128'(r_chan_o), 128'(held));
                held         = r_chan_o;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, w0, n0, s0;
        rst_i     = 1'b1;
        r_ready_i = 1'b1;
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_r_valid_o", 128'(r_valid_o), 128'd0);
        check("reset_r_ready_o", 128'(r_ready_o), 128'd1);
        check("reset_xsarq_pop", 128'(xsarq_pop), 128'd0);
        check("reset_protocol_err", 128'(protocol_err_o), 128'd0);
        rst_i = 1'b0;
        tick();

        // same_size burst: one element per wide beat
        p0 = pop_cnt; w0 = wide_hs_cnt;
        add_burst(mk_desc(4'd1, 3'd3, 16'd0, 32'h100, 1'b1, 6'd0, 8'd3, 1'b1), 4, -1);
        run_to_idle("direct", 100);
        check("direct_pops", 128'(pop_cnt - p0), 128'd1);
        check("direct_wide_hs", 128'(wide_hs_cnt - w0), 128'd4);
        check("direct_err", 128'(protocol_err_o), 128'd0);

        // strided loop: 8 elements per wide beat, no bubble across beats
        p0 = pop_cnt; w0 = wide_hs_cnt; n0 = hs_cyc.size();
        add_burst(mk_desc(4'd2, 3'd2, 16'd1, 32'h204, 1'b0, 6'd4, 8'd15, 1'b1), 2, -1);
        run_to_idle("loop", 100);
        check("loop_pops", 128'(pop_cnt - p0), 128'd1);
        check("loop_wide_hs", 128'(wide_hs_cnt - w0), 128'd2);
        check("loop_narrow_count", 128'(hs_cyc.size() - n0), 128'd16);
        if (hs_cyc.size() >= n0 + 16) check("loop_no_bubble", 128'(hs_cyc[n0+15] - hs_cyc[n0]), 128'd15);
        check("loop_err", 128'(protocol_err_o), 128'd0);

        // nest split: two back-to-back descriptors, only the second carries last
        p0 = pop_cnt; n0 = hs_cyc.size();
        add_burst(mk_desc(4'd3, 3'd3, 16'd0, 32'h0, 1'b0, 6'd0, 8'd3, 1'b0), 1, -1);
        add_burst(mk_desc(4'd3, 3'd3, 16'd0, 32'h0, 1'b0, 6'd0, 8'd3, 1'b1), 1, -1);
        run_to_idle("nest", 100);
        check("nest_pops", 128'(pop_cnt - p0), 128'd2);
        check("nest_narrow_count", 128'(hs_cyc.size() - n0), 128'd8);
        check("nest_err", 128'(protocol_err_o), 128'd0);

        // backpressure: narrow ready low for 5 cycles after element 2
        p0 = pop_cnt; w0 = wide_hs_cnt; s0 = stall_cyc;
        add_burst(mk_desc(4'd4, 3'd3, 16'd0, 32'h40, 1'b0, 6'd0, 8'd15, 1'b1), 2, -1);
        stall_at = hs_total + 3;
        run_to_idle("backpressure", 100);
        check("bp_stall_cycles", 128'(stall_cyc - s0), 128'd5);
        check("bp_pops", 128'(pop_cnt - p0), 128'd1);
        check("bp_wide_hs", 128'(wide_hs_cnt - w0), 128'd2);
        check("bp_err", 128'(protocol_err_o), 128'd0);

        // early last on the first of two wide beats
        add_burst(mk_desc(4'd5, 3'd2, 16'd1, 32'h204, 1'b0, 6'd4, 8'd15, 1'b1), 2, 0);
        run_to_idle("early_last", 100);
        check("early_last_err_set", 128'(protocol_err_o), 128'd1);
        repeat (3) tick();
        check("early_last_err_sticky", 128'(protocol_err_o), 128'd1);

        // reset while element 5 of 16 is presented
        add_burst(mk_desc(4'd6, 3'd2, 16'd1, 32'h204, 1'b0, 6'd4, 8'd15, 1'b1), 2, -1);
        run_to_hs(hs_total + 5, 100);
        check("pre_reset_valid", 128'(r_valid_o), 128'd1);
        p0 = pop_cnt;
        rst_i = 1'b1;
        #1;
        check("mid_reset_r_valid_o", 128'(r_valid_o), 128'd0);
        check("mid_reset_r_ready_o", 128'(r_ready_o), 128'd1);
        check("mid_reset_xsarq_pop", 128'(xsarq_pop), 128'd0);
        check("mid_reset_err_cleared", 128'(protocol_err_o), 128'd0);
        exp_q.delete();
        wide_fifo.delete();
        sarq_fifo.delete();
        drive();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick();
        check("mid_reset_no_pop", 128'(pop_cnt - p0), 128'd0);

        p0 = pop_cnt; w0 = wide_hs_cnt;
        add_burst(mk_desc(4'd7, 3'd3, 16'd0, 32'h100, 1'b1, 6'd0, 8'd3, 1'b1), 4, -1);
        run_to_idle("after_reset", 100);
        check("after_reset_pops", 128'(pop_cnt - p0), 128'd1);
        check("after_reset_wide_hs", 128'(wide_hs_cnt - w0), 128'd4);
        check("after_reset_err", 128'(protocol_err_o), 128'd0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
